// File: rtl/product_accum_pkg.sv
// -----------------------------------------------------------------------------
// product_accum_pkg
// Shared types and constants for the product accumulator slice.
//   state_t     : FSM encoding (IDLE / ACCUM / HOLD)
//   PROD_W      : width of the signed input product (8x8 Booth result)
//   DEF_ACC_W   : default accumulator / result width
//   DEF_CNT_W   : default term-counter width
// -----------------------------------------------------------------------------
package product_accum_pkg;

    localparam int PROD_W    = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no open group
        ACCUM = 2'd1,   // group open, summing products
        HOLD  = 2'd2    // result presented downstream
    } state_t;

endpackage

// File: rtl/product_accum_add.sv
// -----------------------------------------------------------------------------
// product_accum_add
// Combinational signed add of an ACC_W accumulator and a sign-extended PROD_W
// product, with two's-complement overflow flag.
//   a    : accumulator operand (signed, ACC_W)
//   b    : product operand (signed, PROD_W), sign-extended internally
//   sum  : result; wraps by default, clamps when PRODUCT_ACCUM_SAT_EN is defined
//   ovf  : operands share a sign and the raw result's sign differs
// Optional feature macro: PRODUCT_ACCUM_SAT_EN (clamp instead of wrap).
// -----------------------------------------------------------------------------
module product_accum_add
    import product_accum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] raw;

    assign b_ext = {{(ACC_W-PROD_W){b[PROD_W-1]}}, b};
    assign raw   = a + b_ext;
    assign ovf   = (a[ACC_W-1] == b_ext[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

`ifdef PRODUCT_ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both operands share a's sign, which gives the clamp direction.
    assign sum = ovf ? (a[ACC_W-1] ? SUM_MIN : SUM_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accum.sv
// -----------------------------------------------------------------------------
// product_accum
// Sums groups of signed 16-bit products. A group opens with the first accepted
// product and closes with the product flagged in_last; the result is then held
// until downstream takes it.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : product handshake (in_product, in_last)
//   out_valid/out_ready  : result handshake (out_sum, out_count, out_ovf)
//   dbg_state            : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and in_ready = !out_valid.
// Optional feature macro: PRODUCT_ACCUM_SAT_EN (saturating accumulation).
// -----------------------------------------------------------------------------
module product_accum
    import product_accum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output state_t            dbg_state
);

    state_t           state, state_n;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             accept;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Starting a group is an add onto zero, which can never overflow, so the
    // same adder serves both IDLE and ACCUM.
    assign add_a = (state == ACCUM) ? acc : '0;

    product_accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (add_a),
        .b   (in_product),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_n = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            if (state == ACCUM) begin
                count <= (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
                ovf   <= ovf | add_ovf;
            end else begin
                count <= CNT_W'(1);
                ovf   <= add_ovf;
            end
        end
    end

    // Result fields read as zero outside HOLD.
    assign out_sum   = out_valid ? acc   : '0;
    assign out_count = out_valid ? count : '0;
    assign out_ovf   = out_valid ? ovf   : 1'b0;

endmodule
